multi_sync_filt: RTL

MULTI_SYNC_FILT -- requirements
Module: multi_sync_filt

---
 rtl/multi_sync_filt.sv | 62 ++++++
 1 files changed

// File: rtl/multi_sync_filt.sv
// multi_sync_filt: per-channel synchroniser, stability filter, edge pulses and sticky event flags
module multi_sync_filt #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter bit RST_VAL     = 1'b0,
  parameter int EVT_MODE    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] rise_p,
  output logic [CHANNELS-1:0] fall_p,
  input  logic [CHANNELS-1:0] evt_clr,
  output logic [CHANNELS-1:0] evt_flag
);
  localparam int CW = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] synced, sig_out_d, evt_set;
  assign synced = sync[SYNC_STAGES-1];
  // plain flop chain per channel, stage 0 samples the raw input
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {(SYNC_STAGES*CHANNELS){RST_VAL}};
    else sync <= {sync[SYNC_STAGES-2:0], async_in};
  if (FILT_CYCLES == 0) begin : g_byp
    logic [CHANNELS-1:0] q;
    // filter bypassed: register the synced level every cycle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= {CHANNELS{RST_VAL}};
      else q <= synced;
    assign sig_out = q;
  end else begin : g_filt
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic q;
      // count consecutive mismatching cycles; adopt the synced level on the last one
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          cnt <= '0;
          q   <= RST_VAL;
        end else if (synced[i] == q) cnt <= '0;
        else if (cnt == CW'(FILT_CYCLES - 1)) begin
          cnt <= '0;
          q   <= synced[i];
        end else cnt <= cnt + 1'b1;
      assign sig_out[i] = q;
    end
  end
  assign rise_p  = sig_out & ~sig_out_d;
  assign fall_p  = ~sig_out & sig_out_d;
  assign evt_set = (EVT_MODE == 0) ? rise_p : (EVT_MODE == 1) ? fall_p : (rise_p | fall_p);
  // delayed copy for edge detection; sticky flags where a new event beats a clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sig_out_d <= {CHANNELS{RST_VAL}};
      evt_flag  <= '0;
    end else begin
      sig_out_d <= sig_out;
      evt_flag  <= evt_set | (evt_flag & ~evt_clr);
    end
endmodule
